// File: rtl/loader_pkg.sv
// Shared definitions for the sample-RAM loader, scanner and RAM.
//   state_t      : loader FSM states
//   SIZE_DEFAULT : default RAM depth in entries
//   addr_w()     : address width for a given depth (at least 1 bit)
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SIZE_DEFAULT = 32;

  // A depth of 1 would give $clog2()==0; keep the address at least one bit wide.
  function automatic int addr_w(input int size);
    return (size <= 2) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/wr_ptr_counter.sv
// Write pointer and accepted-beat counter for the RAM loader.
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   clr          : zero both ptr and count (new fill)
//   inc_ptr      : advance ptr (saturates at SIZE-1, never wraps)
//   inc_cnt      : advance count (one accepted data beat)
//   ptr          : next RAM write address
//   count        : data beats accepted in current/last fill (0..SIZE)
//   at_last      : ptr is addressing the final entry SIZE-1
module wr_ptr_counter
  import loader_pkg::*;
#(
  parameter int SIZE  = SIZE_DEFAULT,
  parameter int ADDRW = addr_w(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc_ptr,
  input  logic             inc_cnt,
  output logic [ADDRW-1:0] ptr,
  output logic [ADDRW:0]   count,
  output logic             at_last
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SIZE - 1);

  // Explicit compare against SIZE-1 so non-power-of-two depths stop correctly.
  assign at_last = (ptr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (clr) begin
      ptr   <= '0;
      count <= '0;
    end else begin
      // The final write leaves ptr parked at SIZE-1 until the next clear.
      if (inc_ptr && !at_last) ptr <= ptr + ADDRW'(1);
      if (inc_cnt) count <= count + (ADDRW + 1)'(1);
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Fills the SIZE-entry sample RAM from a valid/ready stream, writing
// consecutive addresses from 0. A stream that ends early (in_last before
// SIZE beats) is completed with zero writes so every entry is defined.
// Completion is signalled by a one-cycle done pulse after the final write.
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   start                : begin a fill (honoured only when idle)
//   in_valid/in_data/in_last, in_ready : input sample stream
//   wen, waddr, wdata    : registered RAM write port (one-cycle latency)
//   busy                 : fill in progress
//   done                 : one-cycle completion pulse
//   count                : data beats accepted in current/last fill
module ram_loader
  import loader_pkg::*;
#(
  parameter int N     = 4,
  parameter int SIZE  = SIZE_DEFAULT,
  parameter int ADDRW = addr_w(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             wen,
  output logic [ADDRW-1:0] waddr,
  output logic [N-1:0]     wdata,
  output logic             busy,
  output logic             done,
  output logic [ADDRW:0]   count
);

  state_t           state;
  logic [ADDRW-1:0] ptr;
  logic             at_last;
  logic             xfer;
  logic             clr;
  logic             inc_ptr;
  logic             inc_cnt;

  assign in_ready = (state == FILL);
  assign busy     = (state != IDLE);
  assign xfer     = in_valid && in_ready;

  // Counter commands: clear on an accepted start, advance on every write.
  assign clr     = (state == IDLE) && start;
  assign inc_cnt = xfer;
  assign inc_ptr = xfer || (state == PAD);

  wr_ptr_counter #(
    .SIZE  (SIZE),
    .ADDRW (ADDRW)
  ) u_ptr (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .inc_ptr (inc_ptr),
    .inc_cnt (inc_cnt),
    .ptr     (ptr),
    .count   (count),
    .at_last (at_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      done  <= 1'b0;
    end else begin
      wen  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          // in_valid is deliberately ignored here, even alongside start.
          if (start) state <= FILL;
        end
        FILL: begin
          if (xfer) begin
            wen   <= 1'b1;
            waddr <= ptr;
            wdata <= in_data;
            // A full RAM ends the fill whether or not in_last is set.
            if (at_last)      state <= DONE;
            else if (in_last) state <= PAD;
          end
        end
        PAD: begin
          wen   <= 1'b1;
          waddr <= ptr;
          wdata <= '0;
          if (at_last) state <= DONE;
        end
        DONE: begin
          // done lands the cycle after the last write, with busy already low.
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

  localparam int N     = 4;
  localparam int SIZE  = 32;
  localparam int ADDRW = 5;

  logic             clk;
  logic             reset;
  logic             start;
  logic             in_valid;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             in_ready;
  logic             wen;
  logic [ADDRW-1:0] waddr;
  logic [N-1:0]     wdata;
  logic             busy;
  logic             done;
  logic [ADDRW:0]   count;

  ram_loader #(.N(N), .SIZE(SIZE)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int exp_addr_q[$];
  int exp_data_q[$];
  int next_addr;
  bit last_write_seen;

  typedef struct {
    logic       rst_n;
    logic       st;
    logic       vld;
    logic       lst;
    logic [3:0] dat;
    logic       exp_ready;
    logic       exp_busy;
    logic       exp_wen;
    logic       exp_done;
    int         exp_count;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample 1 time unit after the edge; check writes against the scoreboard
  // and the done pulse against the previous cycle's final write.
  task automatic tick();
    int ea, ed;
    @(posedge clk);
    #1;
    if (wen) begin
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_write_addr", int'(waddr), -1);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        chk("waddr", int'(waddr), ea);
        chk("wdata", int'(wdata), ed);
      end
    end
    chk("done_timing", int'(done), int'(last_write_seen));
    if (done) chk("busy_in_done_cycle", int'(busy), 0);
    last_write_seen = wen && (int'(waddr) == SIZE - 1);
  endtask

  // One accepted beat; expected write (and any padding) queued as driven.
  task automatic send_beat(input int data, input bit last);
    in_valid = 1'b1;
    in_data  = N'(data);
    in_last  = last;
    chk("in_ready_for_beat", int'(in_ready), 1);
    exp_addr_q.push_back(next_addr);
    exp_data_q.push_back(data);
    next_addr++;
    if (last) begin
      for (int a = next_addr; a < SIZE; a++) begin
        exp_addr_q.push_back(a);
        exp_data_q.push_back(0);
      end
    end
    tick();
    chk("wen_after_transfer", int'(wen), 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    next_addr = 0;
    chk("in_ready_after_start", int'(in_ready), 1);
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 64; k++) begin
      if (done) break;
      if (busy) chk("in_ready_low_after_last", int'(in_ready), 0);
      tick();
    end
    chk(name, int'(done), 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    next_addr = 0;
    last_write_seen = 1'b0;
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;

    // rst_n st vld lst dat | ready busy wen done count
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0};

    // Reset, idle guard, start with simultaneous in_valid (ignored).
    for (int i = 0; i < 7; i++) begin
      reset    = vecs[i].rst_n;
      start    = vecs[i].st;
      in_valid = vecs[i].vld;
      in_last  = vecs[i].lst;
      in_data  = vecs[i].dat;
      tick();
      chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_busy", i),     int'(busy),     int'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_wen", i),      int'(wen),      int'(vecs[i].exp_wen));
      chk($sformatf("vec%0d_done", i),     int'(done),     int'(vecs[i].exp_done));
      chk($sformatf("vec%0d_count", i),    int'(count),    vecs[i].exp_count);
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;

    // Full fill, continuous beats, in_last never set (already in FILL).
    next_addr = 0;
    for (int i = 0; i < SIZE; i++) send_beat(i % 16, 1'b0);
    wait_done("full_fill_done");
    chk("full_fill_count", int'(count), 32);
    tick();
    chk("done_one_cycle", int'(done), 0);
    chk("count_holds", int'(count), 32);

    // Early last with bubbles, then zero padding.
    do_start();
    for (int i = 0; i < 5; i++) begin
      send_beat(9 + i, i == 4);
      if (i < 4) begin
        tick();
        chk("no_write_on_bubble", int'(wen), 0);
      end
    end
    wait_done("early_last_done");
    chk("early_last_count", int'(count), 5);
    tick();

    // in_last on beat 32: no padding; start in the done cycle.
    do_start();
    for (int i = 0; i < SIZE; i++) send_beat(15 - (i % 16), i == SIZE - 1);
    wait_done("last_on_32_done");
    chk("last_on_32_count", int'(count), 32);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_done_cycle_ready", int'(in_ready), 1);

    // start pulsed mid-FILL is ignored.
    next_addr = 0;
    for (int i = 0; i < 3; i++) send_beat(i + 1, 1'b0);
    start = 1'b1;
    send_beat(12, 1'b0);
    start = 1'b0;
    chk("count_after_mid_start", int'(count), 4);
    for (int i = 4; i < SIZE; i++) send_beat(i % 16, 1'b0);
    wait_done("mid_start_done");
    chk("mid_start_count", int'(count), 32);
    tick();

    // Reset mid-PAD at waddr 12, then restart from address 0.
    do_start();
    for (int i = 0; i < 3; i++) send_beat(4 + i, i == 2);
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (wen && int'(waddr) == 12) begin
          hit = 1'b1;
          break;
        end
        tick();
      end
      chk("reached_pad_addr12", int'(hit), 1);
    end
    exp_addr_q.delete();
    exp_data_q.delete();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_pad_reset_wen", int'(wen), 0);
    chk("mid_pad_reset_busy", int'(busy), 0);
    chk("mid_pad_reset_count", int'(count), 0);
    chk("mid_pad_reset_ready", int'(in_ready), 0);
    tick();
    chk("idle_after_reset_wen", int'(wen), 0);
    do_start();
    send_beat(10, 1'b0);
    send_beat(11, 1'b1);
    wait_done("restart_done");
    chk("restart_count", int'(count), 2);
    tick();

    chk("leftover_expected_writes", exp_addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Write-side counterpart of the RAM scanner: fills the SIZE-entry sample RAM that the highest/second-highest search block reads sequentially.
- Accepts a valid/ready stream of N-bit values and writes them to consecutive addresses starting at 0.
- If the stream ends early, it zero-pads the remaining entries so the scanner always sees defined data.
- Reports completion with a one-cycle done pulse.

Parameters:
N, 4, data width (matches RAM DATAW)
SIZE, 32, RAM depth in entries; any value >= 2, power of two not required
ADDRW, $clog2(SIZE), address width (derived; not overridden)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 at posedge resets)
start  input  1  begin a fill; honoured only in IDLE
in_valid  input  1  in_data/in_last valid
in_data  input  N  sample value
in_last  input  1  final sample of this fill
in_ready  output  1  loader can accept a beat
wen  output  1  RAM write strobe
waddr  output  ADDRW  RAM write address
wdata  output  N  RAM write data
busy  output  1  fill in progress
done  output  1  one-cycle pulse: fill complete
count  output  ADDRW+1  data beats accepted in current/last fill (0..SIZE)

Behaviour:
- Reset: state=IDLE, ptr=0, wen=0, waddr=0, wdata=0, done=0, count=0. This makes in_ready=0 and busy=0. RAM contents are untouched.
- States: IDLE, FILL, PAD, DONE. ptr is the internal next-write address.
- Combinational outputs: in_ready = (state==FILL); busy = (state!=IDLE).
- Registered outputs: wen, waddr, wdata, done, count.
- Transfer: occurs when in_valid && in_ready at a posedge. Beats offered while in_ready=0 are not consumed, and no write occurs for them.
- IDLE:
  - start=1 -> FILL, ptr=0, count=0.
  - in_valid is ignored, including when asserted in the same cycle as start.
- FILL, on a transfer:
  - Next cycle: wen=1, waddr=ptr, wdata=in_data. count+1, ptr+1.
  - Write latency is exactly one cycle.
  - If ptr==SIZE-1 -> DONE, regardless of in_last.
  - Else if in_last -> PAD.
  - Else stay in FILL.
- FILL, no transfer: wen=0 next cycle. No timeout.
- PAD, every cycle:
  - Next cycle: wen=1, waddr=ptr, wdata=0. ptr+1; count unchanged.
  - When ptr==SIZE-1 is written -> DONE.
  - Writes are back-to-back with no gaps.
- DONE, one cycle:
  - Next cycle: wen=0, done=1, state=IDLE.
  - done is therefore high in the cycle after the final wen, while busy=0.
  - A start in the done=1 cycle is honoured.
- done is 0 in all other cycles.
- count holds its value after done until the next accepted start.
- start outside IDLE is ignored; there is no abort except reset.
- ptr never exceeds SIZE-1; there is no wrap within a fill. Compare explicitly against SIZE-1.
- Reset mid-fill (any state): next cycle is full reset state. A partially written RAM is permitted.
- Exactly SIZE writes per completed fill, addresses 0..SIZE-1 in ascending order.

Decomposition:
- Package loader_pkg:
  - state enum typedef (IDLE, FILL, PAD, DONE)
  - default SIZE
  - ADDRW derivation function/constant, shared with the scanner and RAM
- Single module; no sub-module required.
- If split, the natural sub-module is wr_ptr_counter (ptr and count, with clear/increment/at-last flag).

Test Plan:
- Reset: hold reset=0 three cycles with start=1, in_valid=1 -> wen=0, done=0, count=0, in_ready=0, busy=0 throughout. No write on the first cycle after release unless start is re-sampled.
- Full fill: start, then 32 continuous beats in_data=i%16, in_last=0 -> wen high 32 consecutive cycles, waddr 0..31, wdata i%16. done=1 exactly one cycle after waddr=31; count=32.
- Early last with bubbles: 5 beats with in_valid gaps, in_last on beat 5 -> writes at addr 0..4 only on transfer cycles. Then 27 back-to-back zero writes at addr 5..31 with in_ready=0. done follows; count=5.
- in_last on beat 32 -> no PAD writes; done the cycle after waddr=31; count=32.
- Protocol guards:
  - in_valid=1 in IDLE -> no wen.
  - start pulsed mid-FILL -> ptr/count not reset.
  - start in done cycle -> in_ready=1 the next cycle.
- Reset mid-PAD at waddr=12 -> next cycle wen=0, busy=0, count=0. A new start restarts writing at addr 0.
